// File: rtl/triadic_branch_condition.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | triadic_branch_condition: per-thread branch evaluation with loop counters |
// | Option macro: TRIADIC_BRANCH_COUNTER_RELOAD_EN       Revision: 1.0       |
// +--------------------------------------------------------------------------+
module triadic_branch_condition #(
  parameter int COUNTER_WIDTH      = 12,
  parameter int THREAD_COUNT       = 8,
  parameter int THREAD_COUNT_WIDTH = 3,
  parameter int INITIAL_THREAD     = 0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          R_zero,
  input  logic                          R_negative,
  input  logic                          IO_Ready,
  input  logic                          Cancel,
  input  logic                          branch_valid,
  input  logic [2:0]                    cond,
  input  logic                          counter_load_en,
  input  logic [COUNTER_WIDTH-1:0]      counter_load_data,
  output logic                          branch_taken,
  output logic [THREAD_COUNT_WIDTH-1:0] branch_thread,
  output logic                          counter_zero
);

  localparam logic [THREAD_COUNT_WIDTH-1:0] C_LAST_THREAD  = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);
  localparam logic [THREAD_COUNT_WIDTH-1:0] C_FIRST_THREAD = THREAD_COUNT_WIDTH'(INITIAL_THREAD);

  localparam logic [2:0] C_COND_NEVER  = 3'd0;
  localparam logic [2:0] C_COND_ALWAYS = 3'd1;
  localparam logic [2:0] C_COND_ZERO   = 3'd2;
  localparam logic [2:0] C_COND_NZERO  = 3'd3;
  localparam logic [2:0] C_COND_NEG    = 3'd4;
  localparam logic [2:0] C_COND_POS    = 3'd5;
  localparam logic [2:0] C_COND_LOOP   = 3'd6;
  localparam logic [2:0] C_COND_CZERO  = 3'd7;

  logic [THREAD_COUNT_WIDTH-1:0] thread_q;
  logic [THREAD_COUNT_WIDTH-1:0] thread_d;

  logic [THREAD_COUNT_WIDTH-1:0] s1_thread_q;
  logic                          s1_zero_q;
  logic                          s1_neg_q;
  logic                          s1_branch_q;
  logic [2:0]                    s1_cond_q;
  logic                          s1_load_q;
  logic [COUNTER_WIDTH-1:0]      s1_data_q;
  logic                          s1_not_nop_q;

  logic [COUNTER_WIDTH-1:0]      counter_q [THREAD_COUNT];
  logic [COUNTER_WIDTH-1:0]      counter_d;

  logic [COUNTER_WIDTH-1:0]      w_count;
  logic                          w_live;
  logic                          w_load;
  logic                          w_cond_met;
  logic                          w_taken;

  logic                          taken_q;
  logic [THREAD_COUNT_WIDTH-1:0] out_thread_q;
  logic                          zero_q;

`ifdef TRIADIC_BRANCH_COUNTER_RELOAD_EN
  logic [COUNTER_WIDTH-1:0]      reload_q [THREAD_COUNT];
`endif

  // The thread slot rotates unconditionally; stalls only suppress the instruction.
  always_comb begin
    thread_d = thread_q + 1'b1;
    if (thread_q == C_LAST_THREAD) begin
      thread_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      thread_q     <= C_FIRST_THREAD;
      s1_thread_q  <= C_FIRST_THREAD;
      s1_zero_q    <= 1'b0;
      s1_neg_q     <= 1'b0;
      s1_branch_q  <= 1'b0;
      s1_cond_q    <= C_COND_NEVER;
      s1_load_q    <= 1'b0;
      s1_data_q    <= '0;
      s1_not_nop_q <= 1'b0;
    end else begin
      thread_q     <= thread_d;
      s1_thread_q  <= thread_q;
      s1_zero_q    <= R_zero;
      s1_neg_q     <= R_negative;
      s1_branch_q  <= branch_valid;
      s1_cond_q    <= cond;
      s1_load_q    <= counter_load_en;
      s1_data_q    <= counter_load_data;
      s1_not_nop_q <= IO_Ready & ~Cancel;
    end
  end

  always_comb begin
    w_count    = counter_q[s1_thread_q];
    w_live     = s1_branch_q & s1_not_nop_q;
    w_load     = s1_load_q & s1_not_nop_q;
    w_cond_met = 1'b0;
    case (s1_cond_q)
      C_COND_NEVER:  w_cond_met = 1'b0;
      C_COND_ALWAYS: w_cond_met = 1'b1;
      C_COND_ZERO:   w_cond_met = s1_zero_q;
      C_COND_NZERO:  w_cond_met = ~s1_zero_q;
      C_COND_NEG:    w_cond_met = s1_neg_q;
      C_COND_POS:    w_cond_met = ~s1_zero_q & ~s1_neg_q;
      C_COND_LOOP:   w_cond_met = (w_count != '0);
      C_COND_CZERO:  w_cond_met = (w_count == '0);
      default:       w_cond_met = 1'b0;
    endcase
    w_taken = w_live & w_cond_met;

    // A load wins over a same-instruction loop decrement; the decision above
    // still uses the pre-update count.
    counter_d = w_count;
    if (w_load) begin
      counter_d = s1_data_q;
    end else if (w_live && (s1_cond_q == C_COND_LOOP)) begin
      if (w_count != '0) begin
        counter_d = w_count - 1'b1;
      end else begin
`ifdef TRIADIC_BRANCH_COUNTER_RELOAD_EN
        counter_d = reload_q[s1_thread_q];
`else
        counter_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int t = 0; t < THREAD_COUNT; t++) begin
        counter_q[t] <= '0;
      end
    end else begin
      counter_q[s1_thread_q] <= counter_d;
    end
  end

`ifdef TRIADIC_BRANCH_COUNTER_RELOAD_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int t = 0; t < THREAD_COUNT; t++) begin
        reload_q[t] <= '0;
      end
    end else if (w_load) begin
      reload_q[s1_thread_q] <= s1_data_q;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      taken_q      <= 1'b0;
      out_thread_q <= '0;
      zero_q       <= 1'b0;
    end else begin
      taken_q      <= w_taken;
      out_thread_q <= s1_thread_q;
      zero_q       <= (counter_d == '0);
    end
  end

  assign branch_taken  = taken_q;
  assign branch_thread = out_thread_q;
  assign counter_zero  = zero_q;

endmodule
`default_nettype wire
